// File: rtl/dummy_alg_pkg.sv
// Shared types and sizing for the dummy_alg matrix-product core.
// N x N matrices of W-bit unsigned elements; IW-bit row/column indices.
package dummy_alg_pkg;
    localparam int N  = 32;
    localparam int W  = 8;
    localparam int IW = $clog2(N);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, MAC, OUT, FIN} state_t;

    typedef logic [N-1:0][W-1:0] row_t;
endpackage

// File: rtl/dummy_alg_core_dot_mac.sv
// Dot-product engine: latches one A row and one B column on i_start, then
// accumulates A[k]*B[k] over N cycles. Wraps mod 2^W unless DUMMY_ALG_SATURATE_EN.
module dot_mac
    import dummy_alg_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  row_t         i_a,
    input  row_t         i_b,
    output logic         o_last,
    output logic [W-1:0] o_acc
);
    row_t           r_a;
    row_t           r_b;
    logic [IW-1:0]  r_k;
    logic           r_busy;
    logic [W-1:0]   r_acc;
    logic [2*W-1:0] w_prod;

    function automatic logic [W-1:0] acc_add(input logic [W-1:0]   acc,
                                             input logic [2*W-1:0] prod);
`ifdef DUMMY_ALG_SATURATE_EN
        logic [2*W:0] sum;
        sum = {{(W+1){1'b0}}, acc} + {1'b0, prod};
        // Products are non-negative, so clamping here is sticky once at max.
        return (sum > {{(W+1){1'b0}}, {W{1'b1}}}) ? {W{1'b1}} : sum[W-1:0];
`else
        return acc + prod[W-1:0];
`endif
    endfunction

    assign w_prod = {{W{1'b0}}, r_a[r_k]} * {{W{1'b0}}, r_b[r_k]};
    assign o_last = r_busy && (r_k == IW'(N-1));
    assign o_acc  = r_acc;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_k    <= '0;
            r_busy <= 1'b0;
            r_acc  <= '0;
        end else if (i_start) begin
            r_a    <= i_a;
            r_b    <= i_b;
            r_k    <= '0;
            r_busy <= 1'b1;
            r_acc  <= '0;
        end else if (r_busy) begin
            r_acc <= acc_add(r_acc, w_prod);
            r_k   <= r_k + IW'(1);
            if (r_k == IW'(N-1))
                r_busy <= 1'b0;
        end
    end
endmodule

// File: rtl/dummy_alg_core.sv
// Sequencer for C = A*B: requests row/column pairs in row-major order and emits
// one C element per iteration. Optional saturation via DUMMY_ALG_SATURATE_EN.
module dummy_alg_core
    import dummy_alg_pkg::*;
(
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          complete,
    input  row_t          matA_row,
    input  row_t          matB_col,
    input  logic          val_rows,
    input  logic [IW-1:0] row_in,
    input  logic [IW-1:0] col_in,
    output logic [IW-1:0] row_req,
    output logic [IW-1:0] col_req,
    output logic          new_request,
    output logic [IW-1:0] row_out,
    output logic [IW-1:0] col_out,
    output logic [W-1:0]  matrix_val,
    output logic          valid_out,
    output logic          done
);
    state_t        r_state;
    logic [IW-1:0] r_row;
    logic [IW-1:0] r_col;
    logic [IW-1:0] r_row_lat;
    logic [IW-1:0] r_col_lat;
    logic          w_start;
    logic          w_last;
    logic [W-1:0]  w_acc;

    assign w_start = (r_state == WAIT) && val_rows;

    dot_mac u_mac (
        .i_clk   (clk_in),
        .i_rst   (rst_in),
        .i_start (w_start),
        .i_a     (matA_row),
        .i_b     (matB_col),
        .o_last  (w_last),
        .o_acc   (w_acc)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state     <= IDLE;
            r_row       <= '0;
            r_col       <= '0;
            r_row_lat   <= '0;
            r_col_lat   <= '0;
            row_req     <= '0;
            col_req     <= '0;
            new_request <= 1'b0;
            row_out     <= '0;
            col_out     <= '0;
            matrix_val  <= '0;
            valid_out   <= 1'b0;
            done        <= 1'b0;
        end else begin
            new_request <= 1'b0;
            valid_out   <= 1'b0;
            case (r_state)
                IDLE, FIN: begin
                    if (complete) begin
                        r_row   <= '0;
                        r_col   <= '0;
                        done    <= 1'b0;
                        r_state <= REQ;
                    end
                end
                REQ: begin
                    new_request <= 1'b1;
                    row_req     <= r_row;
                    col_req     <= r_col;
                    r_state     <= WAIT;
                end
                WAIT: begin
                    if (val_rows) begin
                        r_row_lat <= row_in;
                        r_col_lat <= col_in;
                        r_state   <= MAC;
                    end
                end
                MAC: begin
                    if (w_last)
                        r_state <= OUT;
                end
                OUT: begin
                    valid_out  <= 1'b1;
                    matrix_val <= w_acc;
                    row_out    <= r_row_lat;
                    col_out    <= r_col_lat;
                    if ((r_row == IW'(N-1)) && (r_col == IW'(N-1))) begin
                        done    <= 1'b1;
                        r_state <= FIN;
                    end else begin
                        if (r_col == IW'(N-1)) begin
                            r_col <= '0;
                            r_row <= r_row + IW'(1);
                        end else begin
                            r_col <= r_col + IW'(1);
                        end
                        r_state <= REQ;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dummy_alg_core.sv
// Self-checking bench for dummy_alg_core: drives the memory-side handshake and
// compares every emitted element against a plain-arithmetic matrix product.
module tb_dummy_alg_core;
    import dummy_alg_pkg::*;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          complete;
    row_t          matA_row;
    row_t          matB_col;
    logic          val_rows;
    logic [IW-1:0] row_in;
    logic [IW-1:0] col_in;
    logic [IW-1:0] row_req;
    logic [IW-1:0] col_req;
    logic          new_request;
    logic [IW-1:0] row_out;
    logic [IW-1:0] col_out;
    logic [W-1:0]  matrix_val;
    logic          valid_out;
    logic          done;

    int tests = 0;
    int fails = 0;
    int A[N][N];
    int B[N][N];

    dummy_alg_core dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .complete    (complete),
        .matA_row    (matA_row),
        .matB_col    (matB_col),
        .val_rows    (val_rows),
        .row_in      (row_in),
        .col_in      (col_in),
        .row_req     (row_req),
        .col_req     (col_req),
        .new_request (new_request),
        .row_out     (row_out),
        .col_out     (col_out),
        .matrix_val  (matrix_val),
        .valid_out   (valid_out),
        .done        (done)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    function automatic int model(int r, int c);
        int s;
        s = 0;
        for (int k = 0; k < N; k++)
            s += A[r][k] * B[k][c];
`ifdef DUMMY_ALG_SATURATE_EN
        return (s > (1 << W) - 1) ? (1 << W) - 1 : s;
`else
        return s % (1 << W);
`endif
    endfunction

    task automatic fill(input int mode, input int v);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                A[i][j] = (mode == 0) ? v : int'($urandom_range(0, 255));
                B[i][j] = (mode == 0) ? v : int'($urandom_range(0, 255));
            end
    endtask

    task automatic garbage_bus();
        for (int k = 0; k < N; k++) begin
            matA_row[k] = W'($urandom);
            matB_col[k] = W'($urandom);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst_in = 1'b1;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
    endtask

    task automatic pulse_complete();
        complete = 1'b1;
        @(negedge clk_in);
        complete = 1'b0;
    endtask

    // Serves one request: waits for new_request, answers after dly cycles and
    // waits for the result. Optionally injects a stray val_rows / complete mid-MAC.
    task automatic serve(input int dly, input bit spur, input bit busy_start,
                         output int rr, output int cc, output int wt, output int lat,
                         output int val, output int ro, output int co,
                         output bit ok, output bit early);
        ok = 1'b1; early = 1'b0; rr = -1; cc = -1; lat = 0; val = -1; ro = -1; co = -1;
        wt = 0;
        while (!new_request && wt < 100) begin
            @(negedge clk_in);
            wt++;
        end
        if (!new_request) begin
            ok = 1'b0;
            return;
        end
        rr = int'(row_req);
        cc = int'(col_req);
        for (int i = 0; i < dly; i++) begin
            @(negedge clk_in);
            if (new_request || valid_out) early = 1'b1;
        end
        val_rows = 1'b1;
        row_in   = row_req;
        col_in   = col_req;
        for (int k = 0; k < N; k++) begin
            matA_row[k] = W'(A[rr][k]);
            matB_col[k] = W'(B[k][cc]);
        end
        @(negedge clk_in);
        val_rows = 1'b0;
        garbage_bus();
        while (lat < 100) begin
            @(negedge clk_in);
            lat++;
            if (new_request) early = 1'b1;
            if (valid_out) break;
            val_rows = spur && (lat == 5);
            complete = busy_start && (lat == 8);
            if (val_rows) begin
                row_in = ~row_req;
                col_in = ~col_req;
            end
        end
        val_rows = 1'b0;
        complete = 1'b0;
        if (!valid_out) begin
            ok = 1'b0;
            return;
        end
        val = int'(matrix_val);
        ro  = int'(row_out);
        co  = int'(col_out);
    endtask

    task automatic test_reset();
        int rr, cc, wt, lat, val, ro, co, cnt;
        bit ok, early;
        rst_in = 1'b1; complete = 1'b0; val_rows = 1'b0; row_in = '0; col_in = '0;
        matA_row = '0; matB_col = '0;
        repeat (2) @(negedge clk_in);
        tests++;
        if ({row_req, col_req, new_request, row_out, col_out, matrix_val, valid_out, done} !== '0) begin
            fails++;
            $display("FAIL reset_init: outputs=%h required 0",
                     {row_req, col_req, new_request, row_out, col_out, matrix_val, valid_out, done});
        end
        rst_in = 1'b0;
        @(negedge clk_in);
        fill(1, 0);
        pulse_complete();
        for (int e = 0; e < 2; e++)
            serve(1, 0, 0, rr, cc, wt, lat, val, ro, co, ok, early);
        cnt = 0;
        while (!new_request && cnt < 50) begin
            @(negedge clk_in);
            cnt++;
        end
        val_rows = 1'b1;
        @(negedge clk_in);
        val_rows = 1'b0;
        repeat (4) @(negedge clk_in);
        rst_in = 1'b1;
        #1;
        tests++;
        if ({row_req, col_req, new_request, row_out, col_out, matrix_val, valid_out, done} !== '0) begin
            fails++;
            $display("FAIL reset_mid: outputs=%h required 0",
                     {row_req, col_req, new_request, row_out, col_out, matrix_val, valid_out, done});
        end
        @(negedge clk_in);
        rst_in = 1'b0;
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            val_rows = (i == 10);
            @(negedge clk_in);
            if (new_request || valid_out) cnt++;
        end
        val_rows = 1'b0;
        tests++;
        if (cnt !== 0) begin
            fails++;
            $display("FAIL reset_idle: new_request/valid_out pulses=%0d required 0", cnt);
        end
        pulse_complete();
        serve(1, 0, 0, rr, cc, wt, lat, val, ro, co, ok, early);
        tests++;
        if (!ok || rr !== 0 || cc !== 0 || val !== model(0, 0)) begin
            fails++;
            $display("FAIL reset_restart: ok=%0d req=(%0d,%0d) val=%0d required (0,0) val=%0d",
                     ok, rr, cc, val, model(0, 0));
        end
    endtask

    task automatic test_all_ones();
        int rr, cc, wt, lat, val, ro, co, cnt;
        bit ok, early;
        do_reset();
        fill(0, 1);
        pulse_complete();
        for (int e = 0; e < N * N; e++) begin
            serve(1, 0, 0, rr, cc, wt, lat, val, ro, co, ok, early);
            tests++;
            if (!ok) begin
                fails++;
                $display("FAIL ones_handshake: element %0d timed out", e);
                return;
            end
            tests++;
            if (rr !== e / N || cc !== e % N) begin
                fails++;
                $display("FAIL ones_req: element %0d req=(%0d,%0d) required (%0d,%0d)", e, rr, cc, e / N, e % N);
            end
            tests++;
            if (val !== 32 || ro !== e / N || co !== e % N) begin
                fails++;
                $display("FAIL ones_out: element %0d got val=%0d at (%0d,%0d) required 32 at (%0d,%0d)",
                         e, val, ro, co, e / N, e % N);
            end
            tests++;
            if (lat !== N + 1 || early) begin
                fails++;
                $display("FAIL ones_latency: element %0d latency=%0d overlap=%0d required %0d, 0", e, lat, early, N + 1);
            end
            tests++;
            if (e > 0 && wt !== 1) begin
                fails++;
                $display("FAIL ones_next_req: element %0d request gap=%0d required 1", e, wt);
            end
            tests++;
            if (done !== (e == N * N - 1)) begin
                fails++;
                $display("FAIL ones_done: element %0d done=%0d required %0d", e, done, (e == N * N - 1));
            end
        end
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_in);
            if (new_request || !done) cnt++;
        end
        tests++;
        if (cnt !== 0) begin
            fails++;
            $display("FAIL ones_fin: cycles with new_request or done low=%0d required 0", cnt);
        end
    endtask

    task automatic test_restart();
        int rr, cc, wt, lat, val, ro, co;
        bit ok, early;
        pulse_complete();
        tests++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL restart_done: done=%0d required 0", done);
        end
        serve(1, 0, 0, rr, cc, wt, lat, val, ro, co, ok, early);
        tests++;
        if (!ok || rr !== 0 || cc !== 0 || val !== 32) begin
            fails++;
            $display("FAIL restart_first: ok=%0d req=(%0d,%0d) val=%0d required (0,0) val=32", ok, rr, cc, val);
        end
    endtask

    task automatic test_random();
        int rr, cc, wt, lat, val, ro, co, dly;
        bit ok, early;
        do_reset();
        fill(1, 0);
        pulse_complete();
        for (int e = 0; e < 40; e++) begin
            dly = (e == 6) ? 10 : int'($urandom_range(0, 3));
            serve(dly, e == 3, e == 4, rr, cc, wt, lat, val, ro, co, ok, early);
            tests++;
            if (!ok || rr !== e / N || cc !== e % N) begin
                fails++;
                $display("FAIL rand_req: element %0d ok=%0d req=(%0d,%0d) required (%0d,%0d)",
                         e, ok, rr, cc, e / N, e % N);
                return;
            end
            tests++;
            if (val !== model(rr, cc) || ro !== rr || co !== cc) begin
                fails++;
                $display("FAIL rand_val: element %0d got %0d at (%0d,%0d) required %0d at (%0d,%0d)",
                         e, val, ro, co, model(rr, cc), rr, cc);
            end
            tests++;
            if (lat !== N + 1 || early) begin
                fails++;
                $display("FAIL rand_latency: element %0d dly=%0d latency=%0d overlap=%0d required %0d, 0",
                         e, dly, lat, early, N + 1);
            end
        end
    endtask

    task automatic test_wrap();
        int rr, cc, wt, lat, val, ro, co, exp_v;
        bit ok, early;
`ifdef DUMMY_ALG_SATURATE_EN
        exp_v = 255;
`else
        exp_v = 0;
`endif
        do_reset();
        fill(0, 16);
        pulse_complete();
        for (int e = 0; e < 3; e++) begin
            serve(1, 0, 0, rr, cc, wt, lat, val, ro, co, ok, early);
            tests++;
            if (!ok || val !== exp_v) begin
                fails++;
                $display("FAIL wrap_val: element %0d ok=%0d val=%0d required %0d", e, ok, val, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_restart();
        test_random();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
